// File: rtl/ycbcr_block_buffer.sv
// Raster-to-block reorder buffer: captures Y/Cb/Cr raster lines into ping-pong
// 8-line strips and streams each strip out as 8x8 blocks in MCU order (Y, Cb, Cr).
//
// state  | meaning
// IDLE   | waiting for the read bank to be marked full
// STREAM | issuing block-ordered reads of the read bank until its last sample is accepted
module ycbcr_block_buffer #(
  parameter int H_ACTIVE = 720,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_sof,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_cb,
  input  logic [DATA_W-1:0] in_cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic              out_sob,
  output logic              out_eob,
  output logic              out_eof,
  output logic              ovf
);

  localparam int N_BLK   = H_ACTIVE / 8;
  localparam int N_STRIP = V_ACTIVE / 8;
  localparam int COL_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int BLK_W   = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam int STRIP_W = (N_STRIP > 1) ? $clog2(N_STRIP) : 1;
  localparam int DEPTH   = 2 * 8 * H_ACTIVE;
  localparam int ADDR_W  = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  logic [DATA_W-1:0] mem_y  [DEPTH];
  logic [DATA_W-1:0] mem_cb [DEPTH];
  logic [DATA_W-1:0] mem_cr [DEPTH];

  logic [COL_W-1:0]   wcol, wcol_e;
  logic [2:0]         wrow, wrow_e;
  logic [STRIP_W-1:0] wstrip, wstrip_e;
  logic               wbank, wr_halt, halt_eff, wr_take, wr_en;
  logic               wcol_last, strip_wrap, full_eff;
  logic [1:0]         full, full_set, full_clr;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;

  rd_state_t          state_q, state_d;
  logic [BLK_W-1:0]   rblk;
  logic [1:0]         rch;
  logic [2:0]         rr, rc;
  logic               rbank, rd_done, sof_pend;
  logic [STRIP_W-1:0] rstrip;
  logic               issue, iss_last, rd_complete, p1_free, out_free;

  logic               p1_valid, p1_sob, p1_eob, p1_eof, p1_last, out_last;
  logic [1:0]         p1_ch;
  logic [DATA_W-1:0]  q_y, q_cb, q_cr, p1_data;

  // in_sof zeroes the position in the same cycle so a coincident sample lands at (0,0)
  assign wcol_e    = in_sof ? '0 : wcol;
  assign wrow_e    = in_sof ? '0 : wrow;
  assign wstrip_e  = in_sof ? '0 : wstrip;
  assign halt_eff  = wr_halt && !in_sof;
  assign wr_take   = in_de && !halt_eff;
  assign full_eff  = full[wbank] && !(rd_complete && (rbank == wbank));
  assign wr_en     = wr_take && !full_eff;
  assign wcol_last = (wcol_e == COL_W'(H_ACTIVE - 1));
  assign strip_wrap = wr_take && wcol_last && (wrow_e == 3'd7);

  assign wr_addr = ADDR_W'(wbank) * ADDR_W'(8 * H_ACTIVE)
                 + ADDR_W'(wrow_e) * ADDR_W'(H_ACTIVE)
                 + ADDR_W'(wcol_e);
  assign rd_addr = ADDR_W'(rbank) * ADDR_W'(8 * H_ACTIVE)
                 + ADDR_W'(rr) * ADDR_W'(H_ACTIVE)
                 + ADDR_W'(rblk) * ADDR_W'(8)
                 + ADDR_W'(rc);

  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (strip_wrap)  full_set[wbank] = 1'b1;
    if (rd_complete) full_clr[rbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_y[wr_addr]  <= in_y;
      mem_cb[wr_addr] <= in_cb;
      mem_cr[wr_addr] <= in_cr;
    end
    if (issue) begin
      q_y  <= mem_y[rd_addr];
      q_cb <= mem_cb[rd_addr];
      q_cr <= mem_cr[rd_addr];
    end
  end

  // Counters advance even on overflow so the strip geometry stays aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcol    <= '0;
      wrow    <= '0;
      wstrip  <= '0;
      wbank   <= 1'b0;
      wr_halt <= 1'b0;
      ovf     <= 1'b0;
      full    <= '0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (in_sof) begin
        wcol    <= '0;
        wrow    <= '0;
        wstrip  <= '0;
        wr_halt <= 1'b0;
        ovf     <= 1'b0;
      end
      if (wr_take && full_eff) ovf <= 1'b1;
      if (wr_take) begin
        if (wcol_last) begin
          wcol <= '0;
          if (wrow_e == 3'd7) begin
            wrow  <= '0;
            wbank <= ~wbank;
            if (wstrip_e == STRIP_W'(N_STRIP - 1)) begin
              wstrip  <= '0;
              wr_halt <= 1'b1;
            end else begin
              wstrip <= wstrip_e + STRIP_W'(1);
            end
          end else begin
            wrow <= wrow_e + 3'd1;
          end
        end else begin
          wcol <= wcol_e + COL_W'(1);
        end
      end
    end
  end

  assign out_free    = !out_valid || out_ready;
  assign p1_free     = !p1_valid || out_free;
  assign rd_complete = out_valid && out_ready && out_last;
  assign iss_last    = (rblk == BLK_W'(N_BLK - 1)) && (rch == 2'd2) && (rr == 3'd7) && (rc == 3'd7);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (full[rbank] && p1_free) begin
          issue   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!rd_done && p1_free) issue = 1'b1;
        if (rd_complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rblk     <= '0;
      rch      <= '0;
      rr       <= '0;
      rc       <= '0;
      rd_done  <= 1'b0;
      rbank    <= 1'b0;
      rstrip   <= '0;
      sof_pend <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        if (iss_last) begin
          rblk    <= '0;
          rch     <= '0;
          rr      <= '0;
          rc      <= '0;
          rd_done <= 1'b1;
        end else if (rc != 3'd7) begin
          rc <= rc + 3'd1;
        end else begin
          rc <= '0;
          if (rr != 3'd7) begin
            rr <= rr + 3'd1;
          end else begin
            rr <= '0;
            if (rch != 2'd2) begin
              rch <= rch + 2'd1;
            end else begin
              rch  <= '0;
              rblk <= rblk + BLK_W'(1);
            end
          end
        end
      end
      if (rd_complete) begin
        rd_done <= 1'b0;
        rbank   <= ~rbank;
      end
      // A frame start during a strip read takes effect once that strip is done
      if (rd_complete) begin
        if (sof_pend || in_sof || rstrip == STRIP_W'(N_STRIP - 1)) rstrip <= '0;
        else rstrip <= rstrip + STRIP_W'(1);
        sof_pend <= 1'b0;
      end else if (in_sof) begin
        if (state_q == IDLE) rstrip <= '0;
        else sof_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    case (p1_ch)
      2'd1:    p1_data = q_cb;
      2'd2:    p1_data = q_cr;
      default: p1_data = q_y;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid  <= 1'b0;
      p1_ch     <= '0;
      p1_sob    <= 1'b0;
      p1_eob    <= 1'b0;
      p1_eof    <= 1'b0;
      p1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_eof   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (p1_free) begin
        p1_valid <= issue;
        p1_ch    <= rch;
        p1_sob   <= (rr == 3'd0) && (rc == 3'd0);
        p1_eob   <= (rr == 3'd7) && (rc == 3'd7);
        p1_last  <= iss_last;
        p1_eof   <= iss_last && (rstrip == STRIP_W'(N_STRIP - 1));
      end
      if (out_free) begin
        out_valid <= p1_valid;
        if (p1_valid) begin
          out_data <= p1_data;
          out_ch   <= p1_ch;
        end
        out_sob  <= p1_valid && p1_sob;
        out_eob  <= p1_valid && p1_eob;
        out_eof  <= p1_valid && p1_eof;
        out_last <= p1_valid && p1_last;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Directed bench for ycbcr_block_buffer on a 16x16 image: block order, flags,
// backpressure, overflow, mid-frame in_sof and reset during streaming.
module tb_ycbcr_block_buffer;
  localparam int H = 16;
  localparam int V = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_sof = 1'b0;
  logic          in_de = 1'b0;
  logic [DW-1:0] in_y = '0, in_cb = '0, in_cr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_sob, out_eob, out_eof, ovf;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_acc = 0;
  int            rdy_mode = 1;
  int            img_ofs = 0;
  bit            mon_en = 1'b0;
  logic [12:0]   exp_q[$];
  logic [12:0]   obs_word;

  always #5 clk = ~clk;

  ycbcr_block_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_sof(in_sof), .in_de(in_de),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sob(out_sob), .out_eob(out_eob), .out_eof(out_eof),
    .ovf(ovf)
  );

  assign obs_word = {out_data, out_ch, out_sob, out_eob, out_eof};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [12:0] exp_word(int s, int blk, int ch, int r, int c, int ofs);
    int row = s * 8 + r;
    int col = blk * 8 + c;
    logic [7:0] y, d;
    y = 8'((row * 16 + col + ofs) & 255);
    d = (ch == 0) ? y : (ch == 1) ? ~y : 8'((col + ofs) & 255);
    return {d, 2'(ch), (r == 0 && c == 0), (r == 7 && c == 7),
            (s == 1 && blk == 1 && ch == 2 && r == 7 && c == 7)};
  endfunction

  task automatic push_strip(input int s, input int ofs);
    for (int blk = 0; blk < 2; blk++)
      for (int ch = 0; ch < 3; ch++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            exp_q.push_back(exp_word(s, blk, ch, r, c, ofs));
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 0);
      end else begin
        chk($sformatf("sample%0d", n_acc), 32'(obs_word), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic px(input int row, input int col, input bit sof);
    @(posedge clk);
    #1;
    in_de  = 1'b1;
    in_sof = sof;
    in_y   = 8'((row * 16 + col + img_ofs) & 255);
    in_cb  = ~in_y;
    in_cr  = 8'((col + img_ofs) & 255);
  endtask

  task automatic idle_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_de  = 1'b0;
      in_sof = 1'b0;
    end
  endtask

  task automatic send_rows(input int r0, input int n, input bit sof);
    for (int r = r0; r < r0 + n; r++)
      for (int c = 0; c < 16; c++)
        px(r, c, sof && r == r0 && c == 0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_de = 1'b0;
    in_sof = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {out_valid, out_data, out_ch, out_sob, out_eob, out_eof, ovf}, 0);
    exp_q.delete();
    n_acc = 0;
    img_ofs = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // A: full frame, ready high, latency, extra lines after the frame
    rdy_mode = 1;
    do_reset();
    push_strip(0, 0);
    push_strip(1, 0);
    send_rows(0, 8, 1'b1);
    @(posedge clk);
    #1 in_de = 1'b0;
    @(negedge clk); chk("lat_e0", 32'(out_valid), 0);
    @(negedge clk); chk("lat_e1", 32'(out_valid), 0);
    @(negedge clk); chk("lat_e2", 32'(out_valid), 1);
    send_rows(8, 8, 1'b0);
    send_rows(0, 8, 1'b0);
    idle_n(1);
    wait_drain(2000);
    idle_n(100);
    chk("count_a", n_acc, 768);
    chk("ovf_a", 32'(ovf), 0);

    // B: random backpressure, identical sequence and stall stability
    rdy_mode = 2;
    do_reset();
    push_strip(0, 0);
    push_strip(1, 0);
    send_rows(0, 16, 1'b1);
    idle_n(1);
    wait_drain(5000);
    idle_n(20);
    chk("count_b", n_acc, 768);
    chk("ovf_b", 32'(ovf), 0);

    // C: in_sof with in_de mid-frame while strip 0 is being read
    rdy_mode = 1;
    do_reset();
    push_strip(0, 0);
    push_strip(0, 37);
    push_strip(1, 37);
    send_rows(0, 8, 1'b1);
    send_rows(8, 3, 1'b0);
    img_ofs = 37;
    send_rows(0, 8, 1'b1);
    idle_n(300);
    send_rows(8, 8, 1'b0);
    idle_n(1);
    wait_drain(3000);
    idle_n(20);
    chk("count_c", n_acc, 1152);
    chk("ovf_c", 32'(ovf), 0);

    // D: overflow with the sink stalled, cleared by in_sof
    rdy_mode = 0;
    do_reset();
    mon_en = 1'b0;
    send_rows(0, 16, 1'b1);
    idle_n(2);
    chk("ovf_before", 32'(ovf), 0);
    send_rows(0, 8, 1'b1);
    idle_n(2);
    chk("ovf_set", 32'(ovf), 1);
    @(posedge clk);
    #1 in_sof = 1'b1;
    @(posedge clk);
    #1 in_sof = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(ovf), 0);

    // E: reset during STREAM, then a clean frame
    rdy_mode = 1;
    do_reset();
    push_strip(0, 0);
    send_rows(0, 8, 1'b1);
    idle_n(40);
    chk("pre_rst_progress", 32'(n_acc > 0), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    chk("rst_midstream", {out_valid, out_data, out_ch, out_sob, out_eob, out_eof, ovf}, 0);
    exp_q.delete();
    n_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    img_ofs = 5;
    push_strip(0, 5);
    push_strip(1, 5);
    send_rows(0, 16, 1'b1);
    idle_n(1);
    wait_drain(2000);
    idle_n(20);
    chk("count_e", n_acc, 768);
    chk("ovf_e", 32'(ovf), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
